// File: rtl/data_mem_responder_pkg.sv
// Shared data-memory definitions: memMode access encodings and MMIO register offsets.
package data_mem_responder_pkg;

  localparam int MMD = 3;

  localparam logic [MMD-1:0] MM_WORD  = 3'd0;
  localparam logic [MMD-1:0] MM_HALF  = 3'd1;
  localparam logic [MMD-1:0] MM_HALFU = 3'd2;
  localparam logic [MMD-1:0] MM_BYTE  = 3'd3;
  localparam logic [MMD-1:0] MM_BYTEU = 3'd4;

  localparam logic [3:0] MMIO_LED = 4'h0;
  localparam logic [3:0] MMIO_CYC = 4'h4;
  localparam logic [3:0] MMIO_STC = 4'h8;
  localparam logic [3:0] MMIO_FLT = 4'hC;

  function automatic logic mode_legal(input logic [MMD-1:0] mode);
    return mode <= MM_BYTEU;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational lane steering: merges store data into the addressed lanes and
// extracts/extends the load lane. Zero latency, no flow control.
module data_mem_responder_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0]    word,
  input  logic [1:0]     lane,
  input  logic [MMD-1:0] mode,
  input  logic [31:0]    store_data,
  output logic [31:0]    merged,
  output logic [31:0]    load_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = lane[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[{lane, 3'b000} +: 8];

  always_comb begin
    merged    = word;
    load_data = '0;
    case (mode)
      MM_WORD: begin
        merged    = store_data;
        load_data = word;
      end
      MM_HALF, MM_HALFU: begin
        merged    = lane[1] ? {store_data[15:0], word[15:0]} : {word[31:16], store_data[15:0]};
        load_data = (mode == MM_HALF) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      end
      MM_BYTE, MM_BYTEU: begin
        merged[{lane, 3'b000} +: 8] = store_data[7:0];
        load_data = (mode == MM_BYTE) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      default: begin
        merged    = word;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: RAM with byte/half/word lanes plus a 16-byte MMIO window.
// Latency: loads are combinational (0 cycles), stores commit on the next clk edge.
// Backpressure: none, the responder never stalls the CPU.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter string       INIT_FILE   = "data.hex"
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic [31:0]    dataAddress,
  input  logic [31:0]    writeMemData,
  input  logic           memRead,
  input  logic           memWrite,
  input  logic [MMD-1:0] memMode,
  output logic [31:0]    readMemData,
  output logic [31:0]    ledOut,
  output logic           fault
);

  localparam int unsigned IDXW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]     led_q, cyc_q, stc_q;
  logic            fault_q;
  logic [IDXW-1:0] idx;
  logic [3:0]      off;
  logic [31:0]     ram_word, merged, lane_data, mmio_data;
  logic            in_ram, in_mmio, aligned, bad, ram_we, led_we;

  assign idx      = dataAddress[IDXW+1:2];
  assign off      = dataAddress[3:0];
  assign ram_word = mem[idx];
  assign in_ram   = dataAddress < RAM_BYTES;
  assign in_mmio  = dataAddress[31:4] == MMIO_BASE[31:4];

  data_mem_responder_lane_align u_lane_align (
    .word       (ram_word),
    .lane       (dataAddress[1:0]),
    .mode       (memMode),
    .store_data (writeMemData),
    .merged     (merged),
    .load_data  (lane_data)
  );

  always_comb begin
    aligned = 1'b1;
    case (memMode)
      MM_WORD:           aligned = dataAddress[1:0] == 2'b00;
      MM_HALF, MM_HALFU: aligned = !dataAddress[0];
      default:           aligned = 1'b1;
    endcase
  end

  // MMIO is word-only and only the LED register accepts stores.
  assign bad = (memRead || memWrite) &&
               (!mode_legal(memMode) || !aligned || !(in_ram || in_mmio) ||
                (in_mmio && ((memMode != MM_WORD) || (memWrite && off != MMIO_LED))));

  assign ram_we = memWrite && !bad && in_ram;
  assign led_we = memWrite && !bad && in_mmio;

  always_comb begin
    mmio_data = '0;
    case (off)
      MMIO_LED: mmio_data = led_q;
      MMIO_CYC: mmio_data = cyc_q;
      MMIO_STC: mmio_data = stc_q;
      MMIO_FLT: mmio_data = {31'b0, fault_q};
      default:  mmio_data = '0;
    endcase
  end

  assign readMemData = (memRead && !bad) ? (in_ram ? lane_data : mmio_data) : '0;

  // RAM is never reset, but a store in a cycle with reset held low must not land.
  always_ff @(posedge clk) begin
    if (rstN && ram_we) mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      led_q   <= '0;
      cyc_q   <= '0;
      stc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (ram_we) stc_q <= stc_q + 32'd1;
      if (led_we) led_q <= writeMemData;
      if (bad)    fault_q <= 1'b1;
    end
  end

  assign ledOut = led_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-array reference model, directed plus random accesses.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] MBASE = 32'hFFFF_0000;
  localparam int unsigned RAMB  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] dataAddress = '0;
  logic [31:0] writeMemData = '0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  memMode = '0;
  logic [31:0] readMemData, ledOut;
  logic        fault;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .MMIO_BASE   (MBASE),
    .INIT_FILE   ("data.hex")
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .dataAddress  (dataAddress),
    .writeMemData (writeMemData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memMode      (memMode),
    .readMemData  (readMemData),
    .ledOut       (ledOut),
    .fault        (fault)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] rd;
    logic [31:0] led;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state: RAM as a plain byte array, registers as counters.
  logic [7:0]  mem_m [RAMB];
  logic [31:0] led_m = '0, cyc_m = '0, stc_m = '0;
  logic        flt_m = 1'b0;
  int unsigned cyc_no = 0;

  function automatic int unsigned acc_size(input logic [2:0] m);
    case (m)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_bad(input logic [31:0] a, input logic [2:0] m, input bit rd, input bit wr);
    int unsigned sz;
    sz = acc_size(m);
    if (!rd && !wr) return 1'b0;
    if (sz == 0) return 1'b1;
    if (a % sz != 0) return 1'b1;
    if (a < RAMB) return 1'b0;
    if (a >= MBASE && (a - MBASE) < 16) return (sz != 4) || (wr && a != MBASE);
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] m);
    int unsigned sz;
    logic [31:0] v;
    sz = acc_size(m);
    v  = '0;
    if (a < RAMB) begin
      for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mem_m[a + i];
      if (m == 3'd1) v = {{16{v[15]}}, v[15:0]};
      if (m == 3'd3) v = {{24{v[7]}}, v[7:0]};
      return v;
    end
    case (a - MBASE)
      32'd0:   return led_m;
      32'd4:   return cyc_m;
      32'd8:   return stc_m;
      32'd12:  return {31'b0, flt_m};
      default: return '0;
    endcase
  endfunction

  // One bus cycle: drive inputs, queue what the DUT must show this cycle, then
  // advance the model across the coming edge.
  task automatic step(input bit rst_low, input bit rd, input bit wr, input logic [2:0] m,
                      input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit   bad;
    @(posedge clk);
    #1;
    rstN = !rst_low;
    memRead = rd;
    memWrite = wr;
    memMode = m;
    dataAddress = a;
    writeMemData = wd;
    cyc_no++;
    if (rst_low) begin
      led_m = '0; cyc_m = '0; stc_m = '0; flt_m = 1'b0;
    end
    bad   = is_bad(a, m, rd, wr);
    e.cyc = cyc_no;
    e.rd  = (rd && !bad) ? model_read(a, m) : 32'h0;
    e.led = led_m;
    e.flt = flt_m;
    sb.push_back(e);
    if (!rst_low) begin
      cyc_m++;
      if (bad) flt_m = 1'b1;
      else if (wr && a < RAMB) begin
        for (int i = 0; i < int'(acc_size(m)); i++) mem_m[a + i] = wd[8*i +: 8];
        stc_m++;
      end else if (wr) led_m = wd;
    end
  endtask

  task automatic check(input string name, input int unsigned c, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check("rdata", e.cyc, readMemData, e.rd);
        check("led", e.cyc, ledOut, e.led);
        check("fault", e.cyc, {31'b0, fault}, {31'b0, e.flt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  m;
    int unsigned op, sel;

    step(1, 0, 0, MM_WORD, 32'h0, 32'h0);
    step(1, 0, 0, MM_WORD, 32'h0, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 4, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 8, 32'h0);

    for (int i = 0; i < 64; i++) step(0, 0, 1, MM_WORD, 32'(4 * i), $urandom);

    step(0, 0, 1, MM_WORD, 32'h10, 32'hDEADBEEF);
    step(0, 1, 0, MM_WORD, 32'h10, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 8, 32'h0);
    step(0, 0, 1, MM_WORD, 32'h10, 32'h11223344);
    step(0, 0, 1, MM_BYTE, 32'h13, 32'hAAAA_AA80);
    step(0, 1, 0, MM_WORD, 32'h10, 32'h0);
    step(0, 1, 0, MM_BYTE, 32'h13, 32'h0);
    step(0, 1, 0, MM_BYTEU, 32'h13, 32'h0);
    step(0, 0, 1, MM_HALF, 32'h22, 32'h1234BEEF);
    step(0, 1, 0, MM_HALF, 32'h22, 32'h0);
    step(0, 1, 0, MM_HALFU, 32'h22, 32'h0);
    step(0, 1, 1, MM_WORD, 32'h24, 32'h0BADF00D);
    step(0, 1, 0, MM_WORD, 32'h24, 32'h0);
    step(0, 0, 1, MM_WORD, 32'hFFC, 32'h7654_3210);
    step(0, 1, 0, MM_HALFU, 32'hFFE, 32'h0);
    step(0, 1, 0, MM_WORD, 32'h1000, 32'h0);
    step(1, 0, 0, MM_WORD, 32'h0, 32'h0);
    step(0, 0, 1, MM_WORD, MBASE, 32'h5);
    step(0, 1, 0, MM_WORD, MBASE, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 4, 32'h0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, MM_WORD, 32'h0, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 4, 32'h0);
    step(0, 1, 0, MM_WORD, 32'h11, 32'h0);
    step(0, 1, 0, MM_WORD, 32'h10, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 8, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 12, 32'h0);
    step(1, 0, 0, MM_WORD, 32'h0, 32'h0);
    step(0, 0, 1, MM_WORD, MBASE + 4, 32'h1234);
    step(0, 1, 0, MM_WORD, MBASE + 4, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 12, 32'h0);
    step(0, 0, 1, MM_HALF, MBASE, 32'h77);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, 255));
      else if (sel < 9) a = MBASE + 32'($urandom_range(0, 15));
      else              a = 32'h1000 + 32'($urandom_range(0, 15));
      m  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      op = $urandom_range(0, 3);
      step(0, op[0], op[1], m, a, $urandom);
      if (k == 150) step(1, 0, 0, MM_WORD, 32'h0, 32'h0);
    end

    step(0, 0, 1, MM_WORD, MBASE, 32'hA5A5_0001);
    step(1, 0, 1, MM_WORD, 32'h40, 32'hCAFEF00D);
    step(0, 1, 0, MM_WORD, 32'h40, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 4, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 8, 32'h0);
    step(0, 1, 0, MM_WORD, MBASE + 12, 32'h0);
    step(0, 0, 0, MM_WORD, 32'h0, 32'h0);

    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
